// File: rtl/ft_tx_arbiter_if.sv
// Bus bundle for ft_tx_arbiter: the FTDI-side read port, two FWFT source ports and debug taps.
// A word moves when re_i is high and empty_o is low; the active source is popped in that same cycle.
interface ft_tx_arbiter_if #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int IQ_PAIR_WIDTH = 24
);
    // FTDI side
    logic                     re_i;
    logic [FT_DATA_WIDTH-1:0] data_o;
    logic                     empty_o;
    logic                     enough_o;
    logic                     data_incomming_o;
    logic [1:0]               mode_o;

    // IQ sample FIFO (first-word fall-through)
    logic [IQ_PAIR_WIDTH-1:0] fifo_data_i;
    logic                     fifo_empty_i;
    logic                     fifo_enough_i;
    logic                     fifo_data_incomming_i;
    logic                     fifo_re_o;

    // CPU message FIFO (first-word fall-through)
    logic [FT_DATA_WIDTH-1:0] cpu_data_i;
    logic                     cpu_empty_i;
    logic                     cpu_data_incomming_i;
    logic                     cpu_re_o;

    // Internal packet position and sequence number
    logic [15:0]              dbg_word_cnt;
    logic [15:0]              dbg_seq;

    modport slave (
        input  re_i, fifo_data_i, fifo_empty_i, fifo_enough_i, fifo_data_incomming_i,
               cpu_data_i, cpu_empty_i, cpu_data_incomming_i,
        output data_o, empty_o, enough_o, data_incomming_o, mode_o,
               fifo_re_o, cpu_re_o, dbg_word_cnt, dbg_seq
    );

    modport master (
        output re_i, fifo_data_i, fifo_empty_i, fifo_enough_i, fifo_data_incomming_i,
               cpu_data_i, cpu_empty_i, cpu_data_incomming_i,
        input  data_o, empty_o, enough_o, data_incomming_o, mode_o,
               fifo_re_o, cpu_re_o, dbg_word_cnt, dbg_seq
    );
endinterface

// File: rtl/ft_tx_arbiter.sv
// Packet-granular arbiter feeding an FTDI FIFO from an IQ sample FIFO and a CPU message FIFO.
// Define FT_TX_ARBITER_HEADER_EN to prefix every packet with an internal header word.
module ft_tx_arbiter #(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16,
    parameter int PACKET_WORDS     = 256
) (
    input  logic           clk_i,
    input  logic           reset_n,
    ft_tx_arbiter_if.slave bus
);
    localparam int HALF = IQ_PAIR_WIDTH / 2;
    localparam int CW   = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PACKET_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIFO = 2'd1,
        ST_CPU  = 2'd2
    } state_t;

    state_t                   state, state_nxt, arb_state;
    logic [CW-1:0]            word_cnt;
    logic [15:0]              seq;
    logic                     last_src_cpu;
    logic                     arb_last_cpu;
    logic                     hdr_phase;
    logic [FT_DATA_WIDTH-1:0] hdr_data;
    logic [FT_DATA_WIDTH-1:0] fifo_word;
    logic [FT_DATA_WIDTH-1:0] data_mux;
    logic                     src_empty;
    logic                     enough;
    logic                     accept;
    logic                     last_word;

`ifdef FT_TX_ARBITER_HEADER_EN
    logic [31:0] hdr_word;
    assign hdr_word  = {8'hA5, 6'b0, state, seq};
    assign hdr_data  = FT_DATA_WIDTH'(hdr_word);
    assign hdr_phase = (state != ST_IDLE) && (word_cnt == '0);
`else
    assign hdr_data  = '0;
    assign hdr_phase = 1'b0;
`endif

    // IQ halves land in fixed lanes of the output word; unused bits stay zero.
    always_comb begin
        fifo_word = '0;
        fifo_word[HALF-1:0] = bus.fifo_data_i[HALF-1:0];
        fifo_word[QSTART_BIT_INDEX +: HALF] = bus.fifo_data_i[IQ_PAIR_WIDTH-1 -: HALF];
    end

    always_comb begin
        data_mux  = '0;
        src_empty = 1'b1;
        enough    = 1'b0;
        case (state)
            ST_FIFO: begin
                data_mux  = fifo_word;
                src_empty = bus.fifo_empty_i;
                enough    = bus.fifo_enough_i;
            end
            ST_CPU: begin
                data_mux  = bus.cpu_data_i;
                src_empty = bus.cpu_empty_i;
                enough    = ~bus.cpu_empty_i;
            end
            default: ;
        endcase
        if (hdr_phase) begin
            data_mux  = hdr_data;
            src_empty = 1'b0;
        end
    end

    assign accept    = bus.re_i & ~src_empty;
    assign last_word = accept && (word_cnt == CNT_LAST);

    // On the closing word the packet just finished counts as the previous source.
    assign arb_last_cpu = (state == ST_IDLE) ? last_src_cpu : (state == ST_CPU);

    always_comb begin
        if (arb_last_cpu && !bus.fifo_empty_i) arb_state = ST_FIFO;
        else if (!bus.cpu_empty_i)             arb_state = ST_CPU;
        else if (!bus.fifo_empty_i)            arb_state = ST_FIFO;
        else                                   arb_state = ST_IDLE;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:         state_nxt = arb_state;
            ST_FIFO, ST_CPU: if (last_word) state_nxt = arb_state;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt     <= '0;
            seq          <= '0;
            last_src_cpu <= 1'b0;
        end else begin
            if (accept) word_cnt <= last_word ? '0 : word_cnt + CW'(1);
            if (last_word) begin
                seq          <= seq + 16'd1;
                last_src_cpu <= (state == ST_CPU);
            end
        end
    end

    assign bus.data_o           = data_mux;
    assign bus.empty_o          = src_empty;
    assign bus.enough_o         = enough;
    assign bus.data_incomming_o = bus.cpu_data_incomming_i | bus.fifo_data_incomming_i;
    assign bus.mode_o           = state;
    assign bus.fifo_re_o        = accept && (state == ST_FIFO) && !hdr_phase;
    assign bus.cpu_re_o         = accept && (state == ST_CPU) && !hdr_phase;
    assign bus.dbg_word_cnt     = 16'(word_cnt);
    assign bus.dbg_seq          = seq;
endmodule

// File: doc/ft_tx_arbiter.md
FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 SHALL have parameter FT_DATA_WIDTH, default 32: FTDI word width.
REQ-002 SHALL have parameter IQ_PAIR_WIDTH, default 24: packed I/Q sample width; even, IQ_PAIR_WIDTH/2 <= QSTART_BIT_INDEX.
REQ-003 SHALL have parameter QSTART_BIT_INDEX, default 16: LSB position of upper sample half in output word; QSTART_BIT_INDEX+IQ_PAIR_WIDTH/2 <= FT_DATA_WIDTH.
REQ-004 SHALL have parameter PACKET_WORDS, default 256: words per packet, >= 2.
REQ-005 SHALL have one clock, clk_i, and an asynchronous, active-low reset, reset_n.
REQ-006 clk_i  in  1  sole clock, all state on rising edge.
REQ-007 reset_n  in  1  async active-low reset.
REQ-008 re_i  in  1  FTDI read strobe; accepted word = re_i & ~empty_o.
REQ-009 data_o  out  FT_DATA_WIDTH  word to FTDI, valid while ~empty_o.
REQ-010 empty_o, enough_o, data_incomming_o  out  1 each  FTDI-side status.
REQ-011 mode_o  out  2  FSM state: 0 IDLE, 1 FIFO, 2 CPU.
REQ-012 fifo_data_i  in  IQ_PAIR_WIDTH; fifo_empty_i, fifo_enough_i, fifo_data_incomming_i  in  1; fifo_re_o  out  1. FWFT IQ sample FIFO.
REQ-013 cpu_data_i  in  FT_DATA_WIDTH; cpu_empty_i, cpu_data_incomming_i  in  1; cpu_re_o  out  1. FWFT CPU message FIFO.

Function
REQ-014 FIFO word SHALL be packed: fifo_data_i upper half at bits [QSTART_BIT_INDEX+IQ_PAIR_WIDTH/2-1:QSTART_BIT_INDEX], lower half at [IQ_PAIR_WIDTH/2-1:0], all other bits 0.
REQ-015 FSM states IDLE/FIFO/CPU; source is switched only at packet boundary (word counter = 0), never mid-packet.
REQ-016 Arbitration at boundary, evaluated every cycle in IDLE and on the cycle the last word of a packet is accepted: if last_src=CPU and ~fifo_empty_i -> FIFO; else if ~cpu_empty_i -> CPU; else if ~fifo_empty_i -> FIFO; else IDLE.
REQ-017 last_src SHALL update to the source of each completed packet; reset value FIFO.
REQ-018 Word counter SHALL increment on each accepted word, wrap PACKET_WORDS-1 -> 0, and hold otherwise.
REQ-019 data_o SHALL combinationally select the active source word; 0 in IDLE.
REQ-020 empty_o = active source empty (header rules per REQ-029); 1 in IDLE.
REQ-021 fifo_re_o / cpu_re_o = re_i & ~empty_o gated to active source only; re_i while empty_o=1 SHALL be ignored and not forwarded.
REQ-022 Source empty mid-packet: state and counter hold, empty_o=1, packet resumes when data returns; no switch.
REQ-023 enough_o = fifo_enough_i in FIFO, ~cpu_empty_i in CPU, 0 in IDLE.
REQ-024 data_incomming_o = cpu_data_incomming_i | fifo_data_incomming_i, combinational, any state.
REQ-025 16-bit packet sequence counter SHALL increment on each completed packet, wrap 0xFFFF -> 0.
REQ-026 Zero-latency path: word accepted in cycle N is popped from source in cycle N; next word visible cycle N+1.

Reset
REQ-027 reset_n low SHALL force, asynchronously: state IDLE, mode_o=0, word counter 0, sequence 0, last_src FIFO; hence empty_o=1, enough_o=0, data_o=0, fifo_re_o=cpu_re_o=0. Reset mid-packet abandons the packet.

Configuration
REQ-028 Macro FT_TX_ARBITER_HEADER_EN SHALL compile the packet header feature in; undefined, every packet word comes from the source.
REQ-029 With macro: word 0 of each packet is internal header {8'hA5, 6'b0, src(2 bits = mode_o), sequence[15:0]} zero-extended/truncated to FT_DATA_WIDTH; header is valid (empty_o=0) immediately on entering FIFO/CPU; accepting it increments the counter but does not pop the source; packet carries PACKET_WORDS-1 source words.

Verification (bench PACKET_WORDS=4)
REQ-030 Reset: reset_n low mid-packet, re_i=1 -> mode_o=0, empty_o=1, both re outputs 0 same cycle; after release, sequence restarts at 0.
REQ-031 Packing: FIFO only, fifo_data_i=24'hABC123 -> data_o=32'h0ABC0123.
REQ-032 Fairness: both sources hold 8 words -> packet order CPU, FIFO, CPU, FIFO; each switch only after 4th accepted word.
REQ-033 Underflow: FIFO empties after 2 words of packet, CPU non-empty -> empty_o=1, mode_o stays 1, cpu_re_o=0; refill -> words 3,4 delivered, then CPU.
REQ-034 Ignored read: IDLE, re_i=1 for 5 cycles -> fifo_re_o=cpu_re_o=0, counter 0.
REQ-035 Header (macro on): CPU packet, sequence 0 -> first word 32'hA5020000, cpu_re_o=0 on that word, then 3 CPU words; next packet header 32'hA5010001.
